branch_pc_unit: RTL
===================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: stall  in  1  hazard hold from pipeline control; 1 = freeze PC.
REQ-005 Port: id_pc  in  16  address of the instruction currently in ID.
REQ-006 Port: br_valid  in  1  ID holds a conditional branch (BEQZ/BNEZ class).
REQ-007 Port: cond_true  in  1  condition-judge result for that branch; 1 = taken.
REQ-008 Port: br_uncond  in  1  ID holds an unconditional PC-relative branch (B).
REQ-009 Port: br_offset  in  16  sign-extended branch offset, in instructions.
REQ-010 Port: jr_valid  in  1  ID holds a jump-register instruction.
REQ-011 Port: jr_target  in  16  register value for the jump.
REQ-012 Port: pc  out  16  current fetch address.
REQ-013 Port: pc_plus1  out  16  pc + 1, modulo 2^16.
REQ-014 Port: flush  out  1  kill the IF/ID instruction; registered.
REQ-015 Port: taken_cnt  out  16  count of redirects taken since reset.

Function
REQ-016 The FSM SHALL have two states, RUN and FLUSH; reset state RUN.
REQ-017 The unit SHALL evaluate a redirect request only in RUN with stall=0.
- Priority: jr_valid, then br_uncond, then (br_valid & cond_true).
REQ-018 Redirect targets SHALL be:
- JR: jr_target.
- Branch: id_pc + 1 + br_offset, 16-bit wrap-around, carry discarded.
REQ-019 On an accepted redirect, the unit SHALL, at the next edge:
- load pc with the target;
- enter FLUSH;
- increment taken_cnt.
REQ-020 In RUN, with stall=0 and no redirect, pc SHALL load pc_plus1 each edge; 16'hFFFF wraps to 16'h0000.
REQ-021 When stall=1, pc, taken_cnt and the state SHALL hold, and all redirect inputs SHALL be ignored that cycle.
REQ-022 flush SHALL be 1 exactly while in FLUSH, i.e. one cycle after the accepting edge.
REQ-023 In FLUSH, all redirect inputs SHALL be ignored, since they come from the wrong-path instruction.
REQ-024 In FLUSH with stall=0: pc SHALL advance to pc_plus1 and the state SHALL return to RUN.
REQ-025 In FLUSH with stall=1: pc SHALL hold, the state SHALL remain FLUSH, and flush SHALL stay 1.
REQ-026 br_valid with cond_true=0 SHALL behave as no redirect (sequential fetch).
REQ-027 taken_cnt SHALL wrap from 16'hFFFF to 16'h0000 without saturation.
REQ-028 pc_plus1 SHALL be combinational from pc. All other outputs SHALL come directly from registers.

Reset
REQ-029 While rst=0, regardless of clk, the unit SHALL force:
- pc=RESET_PC, pc_plus1=RESET_PC+1;
- flush=0, taken_cnt=0, state RUN.
REQ-030 Deassertion of rst SHALL take effect without glitch; the first pc advance SHALL occur at the first rising edge with rst=1 and stall=0.
REQ-031 Reset asserted mid-FLUSH SHALL clear flush immediately; no pending redirect SHALL survive reset.

Verification
REQ-032 Sequential fetch: reset, then 4 edges with stall=0, no requests -> pc 0,1,2,3,4; flush=0; taken_cnt=0.
REQ-033 Conditional branch:
- Stimulus: pc=16'h0010, id_pc=16'h000F, br_valid=1, cond_true=1, br_offset=16'hFFFC.
- Response: next pc=16'h000C, flush=1 for one cycle, taken_cnt=1.
- Same stimulus with cond_true=0 -> pc=16'h0011, flush=0.
REQ-034 Priority: jr_valid=1 (jr_target=16'h1234), br_uncond=1 and br_valid&cond_true=1 in the same cycle -> pc=16'h1234, taken_cnt increments by 1 only.
REQ-035 Ignore rules:
- Redirect request held during the FLUSH cycle -> ignored; pc=target+1.
- Redirect with stall=1 -> pc, state and taken_cnt unchanged.
- stall=1 during FLUSH -> flush stays 1 until stall drops.
REQ-036 Wrap and reset:
- pc=16'hFFFF, no redirect -> pc=16'h0000.
- id_pc=16'hFFFE, br_offset=16'h0005 -> target 16'h0004.
- rst pulled low between edges while in FLUSH -> pc=RESET_PC and flush=0 immediately.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Fetch PC generator with branch/jump redirect, one-cycle wrong-path flush,
// hazard stall hold and a count of redirects taken.
module branch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [15:0] id_pc,
    input  logic        br_valid,
    input  logic        cond_true,
    input  logic        br_uncond,
    input  logic [15:0] br_offset,
    input  logic        jr_valid,
    input  logic [15:0] jr_target,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        flush,
    output logic [15:0] taken_cnt
);

    // state | meaning
    // RUN   | normal fetch, redirect requests from ID are evaluated
    // FLUSH | instruction in IF/ID is wrong-path; requests ignored, flush=1
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state, state_next;
    logic [15:0] pc_next;
    logic [15:0] cnt_next;
    logic        redirect;
    logic [15:0] target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            taken_cnt <= 16'h0000;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            taken_cnt <= cnt_next;
        end
    end

    always_comb begin
        redirect   = 1'b0;
        target     = pc_plus1;
        state_next = state;
        pc_next    = pc;
        cnt_next   = taken_cnt;
        if (state == RUN && !stall) begin
            if (jr_valid) begin
                redirect = 1'b1;
                target   = jr_target;
            end else if (br_uncond || (br_valid && cond_true)) begin
                redirect = 1'b1;
                target   = id_pc + 16'd1 + br_offset;
            end
        end
        // stall freezes everything, including a pending FLUSH
        if (!stall) begin
            if (redirect) begin
                state_next = FLUSH;
                pc_next    = target;
                cnt_next   = taken_cnt + 16'd1;
            end else begin
                state_next = RUN;
                pc_next    = pc_plus1;
            end
        end
    end

    always_comb begin
        pc_plus1 = pc + 16'd1;
        flush    = (state == FLUSH);
    end

endmodule
